// File: rtl/mod4051_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod4051_pkg
//  Description : Shared constants, reduction table and FSM state type for the
//                sequential x mod 4051 reducer.
//  Revision    : 1.0  initial release
// ============================================================================
package mod4051_pkg;

    localparam int MOD    = 4051;
    localparam int W      = 12;
    localparam int X_BITS = 400;
    localparam int CHUNK  = 6;
    localparam int LANES  = 4;
    localparam int NCHUNK = (X_BITS + CHUNK - 1) / CHUNK;   // 67
    localparam int NGROUP = (NCHUNK + LANES - 1) / LANES;   // 17
    localparam int GRP_W  = $clog2(NGROUP);                 // 5
    localparam int SR_W   = NCHUNK * CHUNK;                 // 402
    localparam int SW     = W + 3;                          // holds acc + LANES residues

    // k*MOD for k = 0..LANES, used to fold the partial sum back below MOD
    function automatic logic [LANES:0][SW-1:0] build_mult_tab();
        logic [LANES:0][SW-1:0] t;
        for (int k = 0; k <= LANES; k++) begin
            t[k] = SW'(k * MOD);
        end
        return t;
    endfunction

    localparam logic [LANES:0][SW-1:0] MULT_TAB = build_mult_tab();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mod4051_reduce_seq_lane_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : mod_lane_reduce
//  Description : Adds the running residue to the masked lane residues and
//                folds the sum back into 0..MOD-1 with one table compare.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_lane_reduce
    import mod4051_pkg::*;
(
    input  logic [W-1:0]       acc,
    input  logic [LANES*W-1:0] res,
    input  logic [LANES-1:0]   lane_mask,
    output logic [W-1:0]       z
);

    logic [SW-1:0] sum;
    logic [SW-1:0] diff;

    // Sum the accumulator and every lane that maps to a real chunk position
    always_comb begin
        sum = SW'(acc);
        for (int l = 0; l < LANES; l++) begin
            if (lane_mask[l]) begin
                sum = sum + SW'(res[l*W +: W]);
            end
        end
    end

    // Subtract the largest k*MOD not exceeding the sum (ascending scan keeps the last hit)
    always_comb begin
        diff = sum;
        for (int k = 1; k <= LANES; k++) begin
            if (sum >= MULT_TAB[k]) begin
                diff = sum - MULT_TAB[k];
            end
        end
    end

    assign z = W'(diff);

endmodule
`default_nettype wire

// File: rtl/mod4051_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod4051_reduce_seq
//  Description : Streams a 400-bit operand through the external residue LUT
//                bank LANES chunks per cycle and returns x mod 4051.
//  Revision    : 1.0  initial release
// ============================================================================
module mod4051_reduce_seq
    import mod4051_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_BITS-1:0]      in_x,
    output logic [GRP_W-1:0]       lut_grp,
    output logic [LANES*CHUNK-1:0] lut_chunk,
    input  logic [LANES*W-1:0]     lut_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_z
);

    state_t           state;
    state_t           next_state;
    logic [SR_W-1:0]  sr;
    logic [GRP_W-1:0] grp;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_next;
    logic [LANES-1:0] lane_mask;
    logic             last_grp;
    logic             load;

    assign last_grp  = (grp == GRP_W'(NGROUP - 1));
    assign load      = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_z     = (state == DONE) ? acc : '0;
    assign lut_grp   = (state == RUN) ? grp : '0;
    assign lut_chunk = (state == RUN) ? sr[LANES*CHUNK-1:0] : '0;

    // Lanes past the final chunk position carry no operand bits and are masked off
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_mask[l] = (int'(grp) * LANES + l) < NCHUNK;
    end

    mod_lane_reduce u_reduce (
        .acc       (acc),
        .res       (lut_res),
        .lane_mask (lane_mask),
        .z         (acc_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_grp)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Operand shift register, group counter and residue accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            grp <= '0;
            acc <= '0;
        end else if (load) begin
            sr  <= SR_W'(in_x);
            grp <= '0;
            acc <= '0;
        end else if (state == RUN) begin
            sr  <= sr >> (LANES * CHUNK);
            grp <= grp + GRP_W'(1);
            acc <= acc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod4051_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod4051_reduce_seq
//  Description : Scoreboard bench for mod4051_reduce_seq with a behavioural
//                LUT bank and a bit-serial x mod 4051 reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod4051_reduce_seq;

    localparam int MODV = 4051;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [399:0] in_x = '0;
    logic [4:0]   lut_grp;
    logic [23:0]  lut_chunk;
    logic [47:0]  lut_res;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [11:0]  out_z;

    int checks = 0;
    int passes = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int exp_q[$];

    mod4051_reduce_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .lut_grp   (lut_grp),
        .lut_chunk (lut_chunk),
        .lut_res   (lut_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
    );

    always #5 clk = ~clk;

    // 2^(6*pos) mod MOD by repeated multiplication
    function automatic int pow64_mod(input int pos);
        int p = 1;
        for (int i = 0; i < pos; i++) p = (p * 64) % MODV;
        return p;
    endfunction

    // Reference: Horner over the operand bits, MSB first
    function automatic int ref_mod(input logic [399:0] x);
        int r = 0;
        for (int i = 399; i >= 0; i--) r = (r * 2 + int'(x[i])) % MODV;
        return r;
    endfunction

    // Behavioural LUT bank; positions beyond the operand return a poison value
    always_comb begin
        int pos;
        pos = 0;
        lut_res = '0;
        for (int l = 0; l < 4; l++) begin
            pos = int'(lut_grp) * 4 + l;
            if (pos < 67)
                lut_res[l*12 +: 12] = 12'((int'(lut_chunk[l*6 +: 6]) * pow64_mod(pos)) % MODV);
            else
                lut_res[l*12 +: 12] = 12'd4050;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted result must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_result", int'(out_z), -1);
                else                   check("out_z", int'(out_z), exp_q.pop_front());
            end
        end
    end

    // Present an operand until accepted; called away from clock edges
    task automatic send(input logic [399:0] x, input int expv);
        int n = 0;
        in_x = x;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back(expv);
        #1;
        in_valid = 1'b0;
        in_x = {13{$urandom()}};
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_z"}, int'(out_z), 0);
        check({tag, "_lut_grp"}, int'(lut_grp), 0);
        check({tag, "_lut_chunk"}, int'(lut_chunk), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [399:0] x;
        logic [415:0] wide;
        int n;

        // Reset state
        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // x = 0 with latency measurement
        rdy_mode = 0;
        send('0, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_cycles", n + 1, 18);
        wait_drain();

        // Directed values around the modulus
        x = 400'd4050;  send(x, 4050); wait_drain();
        x = 400'd4051;  send(x, 0);    wait_drain();
        x = 400'd4096;  send(x, 45);   wait_drain();
        x = '0; x[24] = 1'b1; send(x, 2025); wait_drain();
        x = '1;         send(x, ref_mod(x)); wait_drain();

        // Back-pressure: result held, input blocked, stray in_valid ignored
        rdy_mode = 2;
        x = {13{$urandom()}};
        send(x, ref_mod(x));
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_x = {13{$urandom()}};
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_z", int'(out_z), ref_mod(x));
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        wait_drain();

        // Abort mid-run, then a fresh operand must produce only its own result
        @(posedge clk);
        #1;
        x = '1;
        send(x, ref_mod(x));
        n = 0;
        while (lut_grp != 5'd8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_reset_state("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        x = 400'd4096;
        send(x, 45);
        wait_drain();

        // Random operands with random input gaps and output stalls
        rdy_mode = 1;
        for (int t = 0; t < 1000; t++) begin
            wide = {13{$urandom()}};
            for (int i = 0; i < 13; i++) wide[i*32 +: 32] = $urandom();
            x = wide[399:0];
            if ($urandom_range(0, 3) == 0) x = x >> $urandom_range(0, 399);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(x, ref_mod(x));
        end
        rdy_mode = 0;
        wait_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
